speech_writer: RTL

SPEECH_WRITER -- requirements
Module: speech_writer

---
 rtl/speech_pkg.sv | 38 +++
 rtl/byte_pair_packer.sv | 61 ++++++
 rtl/speech_writer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/speech_pkg.sv
// Shared definitions for the speech loader and the speech RAM byte reader:
// FSM state encoding, default RAM capacity, counter/address widths and the
// byte order used when two stream bytes are packed into one RAM word.
package speech_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LO    = 3'd1,
        ST_HI    = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Speech RAM capacity in 16-bit words.
    localparam int MAX_WORDS_DEFAULT = 1048576;

    // word_count must be able to hold MAX_WORDS itself (saturation value).
    localparam int COUNT_W = 21;
    localparam int ADDR_W  = 22;

    // First byte of each pair lands in word bits [7:0] (even byte address).
    localparam bit LOW_BYTE_FIRST = 1'b1;

    // Increment that sticks at the limit instead of wrapping.
    function automatic logic [COUNT_W-1:0] sat_inc(
        input logic [COUNT_W-1:0] count,
        input logic [COUNT_W-1:0] limit
    );
        logic [COUNT_W-1:0] result;
        if (count < limit) begin
            result = count + 21'd1;
        end else begin
            result = count;
        end
        return result;
    endfunction

endpackage

// File: rtl/byte_pair_packer.sv
// Collects two consecutive stream bytes into one 16-bit RAM word.
// half flags that the first byte of a pair is held and the word is incomplete.
// The word register is kept intact when the half flag is dropped so a flush
// write can still present it on the following cycle.
module byte_pair_packer
    import speech_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        accept,
    input  logic        drop_half,
    input  logic [7:0]  byte_in,
    output logic [15:0] word,
    output logic        half
);

    logic [15:0] word_q, word_d;
    logic        half_q, half_d;

    // Next-word computation: first byte clears the other lane, second byte completes it.
    always_comb begin
        word_d = word_q;
        half_d = half_q;
        if (accept) begin
            if (!half_q) begin
                if (LOW_BYTE_FIRST) begin
                    word_d = {8'h00, byte_in};
                end else begin
                    word_d = {byte_in, 8'h00};
                end
                half_d = 1'b1;
            end else begin
                if (LOW_BYTE_FIRST) begin
                    word_d = {byte_in, word_q[7:0]};
                end else begin
                    word_d = {word_q[15:8], byte_in};
                end
                half_d = 1'b0;
            end
        end else if (drop_half) begin
            half_d = 1'b0;
        end else begin
            half_d = half_q;
        end
    end

    // Word latch and half flag, cleared by the synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            word_q <= 16'h0000;
            half_q <= 1'b0;
        end else begin
            word_q <= word_d;
            half_q <= half_d;
        end
    end

    assign word = word_q;
    assign half = half_q;

endmodule

// File: rtl/speech_writer.sv
// Loads a host byte stream into speech RAM as 16-bit words, one utterance at a
// time, then pulses start to launch the recognition core. The core owns the
// RAM while core_busy is high, so loading is refused or aborted then.
module speech_writer
    import speech_pkg::*;
#(
    parameter int MAX_WORDS = MAX_WORDS_DEFAULT
)(
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    input  logic               load_begin,
    input  logic               load_end,
    input  logic               core_busy,
    output logic [ADDR_W-1:0]  speech_addr,
    output logic [15:0]        speech_data,
    output logic               speech_wren,
    output logic [COUNT_W-1:0] word_count,
    output logic               start,
    output logic               full
);

    localparam logic [COUNT_W-1:0] MAX_COUNT = COUNT_W'(MAX_WORDS);

    state_e              state_q, state_d;
    logic [COUNT_W-1:0]  word_count_q, word_count_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wren_q, wren_d;
    logic                start_q, start_d;
    logic                full_q, full_d;
    logic                byte_ready_q, byte_ready_d;

    logic                pk_accept_s;
    logic                pk_drop_s;
    logic                pk_half_s;
    logic [15:0]         pk_word_s;

    logic                xfer_s;
    logic                room_s;
    state_e              after_byte_s;

    assign xfer_s = byte_valid && byte_ready_q;
    assign room_s = (word_count_q < MAX_COUNT);

    byte_pair_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .accept    (pk_accept_s),
        .drop_half (pk_drop_s),
        .byte_in   (byte_in),
        .word      (pk_word_s),
        .half      (pk_half_s)
    );

    // Next state, write strobe, counter and status for every cycle.
    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        addr_d       = addr_q;
        wren_d       = 1'b0;
        start_d      = 1'b0;
        full_d       = full_q;
        pk_accept_s  = 1'b0;
        pk_drop_s    = 1'b0;
        after_byte_s = state_q;

        case (state_q)
            ST_IDLE: begin
                if (load_begin && !core_busy) begin
                    state_d      = ST_LO;
                    word_count_d = 21'd0;
                    full_d       = 1'b0;
                    pk_drop_s    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_LO, ST_HI: begin
                if (core_busy) begin
                    // Core grabbed the RAM: give up, no start, partial byte lost.
                    state_d   = ST_IDLE;
                    pk_drop_s = 1'b1;
                end else begin
                    if (byte_valid && !room_s) begin
                        full_d = 1'b1;
                    end else begin
                        full_d = full_q;
                    end

                    if (xfer_s) begin
                        pk_accept_s = 1'b1;
                        if (state_q == ST_LO) begin
                            after_byte_s = ST_HI;
                        end else begin
                            after_byte_s = ST_LO;
                            wren_d       = 1'b1;
                            addr_d       = {1'b0, word_count_q};
                            word_count_d = sat_inc(word_count_q, MAX_COUNT);
                        end
                    end else begin
                        after_byte_s = state_q;
                    end

                    // An end arriving with a byte is judged after that byte.
                    if (load_end) begin
                        if (after_byte_s == ST_HI) begin
                            state_d = ST_FLUSH;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        state_d = after_byte_s;
                    end
                end
            end

            ST_FLUSH: begin
                // Odd byte count: write the held low byte with a zero high byte.
                if (pk_half_s) begin
                    wren_d       = 1'b1;
                    addr_d       = {1'b0, word_count_q};
                    word_count_d = sat_inc(word_count_q, MAX_COUNT);
                end else begin
                    wren_d = 1'b0;
                end
                pk_drop_s = 1'b1;
                state_d   = ST_DONE;
            end

            ST_DONE: begin
                start_d = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        byte_ready_d = ((state_d == ST_LO) || (state_d == ST_HI)) &&
                       (word_count_d < MAX_COUNT);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            word_count_q <= 21'd0;
            addr_q       <= 22'd0;
            wren_q       <= 1'b0;
            start_q      <= 1'b0;
            full_q       <= 1'b0;
            byte_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
            addr_q       <= addr_d;
            wren_q       <= wren_d;
            start_q      <= start_d;
            full_q       <= full_d;
            byte_ready_q <= byte_ready_d;
        end
    end

    assign byte_ready  = byte_ready_q;
    assign speech_addr = addr_q;
    assign speech_data = pk_word_s;
    assign speech_wren = wren_q;
    assign word_count  = word_count_q;
    assign start       = start_q;
    assign full        = full_q;

endmodule
